// File: rtl/otter_pkg.sv
// Shared OTTER definitions: opcode encodings, sequencer states and FUNC3 constants.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_LWAIT,
    ST_SWAIT,
    ST_INTR
  } cu_state_t;

  localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/cu_fsm_if.sv
// Decoder-side inputs and strobe outputs of the OTTER control-unit sequencer.
interface cu_fsm_if;
  logic [6:0] CU_OPCODE;
  logic [2:0] FUNC3;
  logic       INTR;
  logic       MIE;
  logic       MEM_READY;
  logic       CPU_RST;
  logic       PC_WRITE;
  logic       REG_WRITE;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       CSR_WRITE;
  logic       INT_TAKEN;
  logic       BUS_ERR;
  logic       ILLEGAL;

  modport master (
    input  CU_OPCODE, FUNC3, INTR, MIE, MEM_READY,
    output CPU_RST, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           CSR_WRITE, INT_TAKEN, BUS_ERR, ILLEGAL
  );

  modport slave (
    output CU_OPCODE, FUNC3, INTR, MIE, MEM_READY,
    input  CPU_RST, PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           CSR_WRITE, INT_TAKEN, BUS_ERR, ILLEGAL
  );
endinterface

// File: rtl/cu_fsm.sv
// Multicycle OTTER sequencer: fetch / execute / memory-wait / trap entry, with
// combinational strobes decoded from the current state and inputs.
module cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic       CLK,
  input logic       RST,
  cu_fsm_if.master  bus
);

  localparam int unsigned RcW = $clog2(RST_CYCLES + 1);
  localparam int unsigned WcW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RcW-1:0] RstLast  = RcW'(RST_CYCLES - 1);
  localparam logic [WcW-1:0] WaitLast = WcW'(MEM_TIMEOUT - 1);
  localparam logic [WcW-1:0] WaitMax  = WcW'(MEM_TIMEOUT);

  cu_state_t      state_q, state_d;
  logic [RcW-1:0] rst_cnt_q, rst_cnt_d;
  logic [WcW-1:0] wait_cnt_q, wait_cnt_d;
  logic           int_pend_q;
  logic           pend_now;
  logic           complete;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_INIT;
      rst_cnt_q  <= '0;
      wait_cnt_q <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      // Trap entry consumes the pending request; a request seen in ST_INTR re-arms it.
      if (state_d == ST_INTR)          int_pend_q <= 1'b0;
      else if (bus.INTR && bus.MIE)    int_pend_q <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    complete      = 1'b0;
    pend_now      = int_pend_q | (bus.INTR & bus.MIE);
    bus.CPU_RST   = 1'b0;
    bus.PC_WRITE  = 1'b0;
    bus.REG_WRITE = 1'b0;
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
    bus.CSR_WRITE = 1'b0;
    bus.INT_TAKEN = 1'b0;
    bus.BUS_ERR   = 1'b0;
    bus.ILLEGAL   = 1'b0;

    case (state_q)
      ST_INIT: begin
        bus.CPU_RST = 1'b1;
        if (rst_cnt_q == RstLast) state_d = ST_FETCH;
        else                      rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_FETCH: begin
        bus.MEM_RDEN1 = 1'b1;
        state_d       = ST_EXEC;
      end
      ST_EXEC: begin
        case (bus.CU_OPCODE)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM: begin
            bus.REG_WRITE = 1'b1;
            complete      = 1'b1;
          end
          OP_BRANCH: complete = 1'b1;
          OP_SYSTEM: begin
            if (bus.FUNC3 != F3_MRET) begin
              bus.REG_WRITE = 1'b1;
              bus.CSR_WRITE = 1'b1;
            end
            complete = 1'b1;
          end
          OP_LOAD: begin
            bus.MEM_RDEN2 = 1'b1;
            wait_cnt_d    = '0;
            state_d       = ST_LWAIT;
          end
          OP_STORE: begin
            bus.MEM_WE2 = 1'b1;
            if (bus.MEM_READY) begin
              complete = 1'b1;
            end else begin
              wait_cnt_d = '0;
              state_d    = ST_SWAIT;
            end
          end
          default: begin
            bus.ILLEGAL = 1'b1;
            complete    = 1'b1;
          end
        endcase
      end
      ST_LWAIT, ST_SWAIT: begin
        bus.MEM_RDEN2 = (state_q == ST_LWAIT);
        bus.MEM_WE2   = (state_q == ST_SWAIT);
        if (bus.MEM_READY) begin
          bus.REG_WRITE = (state_q == ST_LWAIT);
          complete      = 1'b1;
        end else if (wait_cnt_q == WaitLast) begin
          bus.BUS_ERR = 1'b1;
          complete    = 1'b1;
        end else begin
          wait_cnt_d = (wait_cnt_q == WaitMax) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
      end
      ST_INTR: begin
        bus.INT_TAKEN = 1'b1;
        bus.PC_WRITE  = 1'b1;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase

    if (complete) begin
      bus.PC_WRITE = 1'b1;
      state_d      = pend_now ? ST_INTR : ST_FETCH;
    end
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Self-checking bench for cu_fsm: per-instruction expected strobe traces built
// from the instruction class, memory latency and interrupt history.
module tb_cu_fsm;

  localparam int T = 15;

  localparam logic [9:0] E_RST  = 10'h200;
  localparam logic [9:0] E_PCW  = 10'h100;
  localparam logic [9:0] E_REGW = 10'h080;
  localparam logic [9:0] E_RD1  = 10'h040;
  localparam logic [9:0] E_RD2  = 10'h020;
  localparam logic [9:0] E_WE2  = 10'h010;
  localparam logic [9:0] E_CSRW = 10'h008;
  localparam logic [9:0] E_INTT = 10'h004;
  localparam logic [9:0] E_BERR = 10'h002;
  localparam logic [9:0] E_ILL  = 10'h001;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OPR = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011, FENCE = 7'b0001111, BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   pend_m = 1'b0;
  logic [6:0] op_tab [12];

  cu_fsm_if bus ();

  cu_fsm #(.RST_CYCLES(2), .MEM_TIMEOUT(T)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.CPU_RST, bus.PC_WRITE, bus.REG_WRITE, bus.MEM_RDEN1, bus.MEM_RDEN2,
            bus.MEM_WE2, bus.CSR_WRITE, bus.INT_TAKEN, bus.BUS_ERR, bus.ILLEGAL};
  endfunction

  function automatic logic [6:0] rand_op();
    return op_tab[$urandom_range(11)];
  endfunction

  // One clock cycle: inputs change just after the edge, outputs are read at the falling edge.
  task automatic drive(input logic r, input logic [6:0] op, input logic [2:0] f3,
                       input logic iv, input logic mv, input logic rdy);
    @(posedge clk);
    #1;
    rst           = r;
    bus.CU_OPCODE = op;
    bus.FUNC3     = f3;
    bus.INTR      = iv;
    bus.MIE       = mv;
    bus.MEM_READY = rdy;
    @(negedge clk);
  endtask

  // ready_at: 0 = ready in EXEC (store only), k = ready in k-th wait cycle, >T = never ready.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input int ready_at, input int irq_pct, input int irq_at,
                           input bit irq_mie);
    logic [9:0] ev [$];
    bit         rq [$];
    bit         hit, pnow, iv, mv;
    int         n;
    logic [9:0] got;
    hit = (ready_at <= T);
    n   = hit ? ready_at : T;
    ev.push_back(E_RD1);
    rq.push_back(1'($urandom_range(1)));
    if (op == LOAD) begin
      ev.push_back(E_RD2);
      rq.push_back(1'($urandom_range(1)));
      for (int k = 1; k <= n; k++) begin
        ev.push_back(k < n ? E_RD2 : (E_RD2 | E_PCW | (hit ? E_REGW : E_BERR)));
        rq.push_back(hit && k == n);
      end
    end else if (op == STORE) begin
      if (ready_at == 0) begin
        ev.push_back(E_WE2 | E_PCW);
        rq.push_back(1'b1);
      end else begin
        ev.push_back(E_WE2);
        rq.push_back(1'b0);
        for (int k = 1; k <= n; k++) begin
          ev.push_back(k < n ? E_WE2 : (E_WE2 | E_PCW | (hit ? 10'h000 : E_BERR)));
          rq.push_back(hit && k == n);
        end
      end
    end else begin
      rq.push_back(1'($urandom_range(1)));
      if (op inside {LUI, AUIPC, JAL, JALR, OPIMM, OPR}) ev.push_back(E_REGW | E_PCW);
      else if (op == BRANCH)                             ev.push_back(E_PCW);
      else if (op == SYSTEM)
        ev.push_back(f3 == 3'b000 ? E_PCW : (E_REGW | E_CSRW | E_PCW));
      else                                               ev.push_back(E_ILL | E_PCW);
    end

    for (int i = 0; i < ev.size(); i++) begin
      iv = (i == irq_at) ? 1'b1 : (int'($urandom_range(99)) < irq_pct);
      mv = (i == irq_at) ? irq_mie : 1'($urandom_range(1));
      drive(1'b0, (i == 0) ? rand_op() : op, (i == 0) ? 3'($urandom_range(7)) : f3,
            iv, mv, rq[i]);
      got = outs();
      checks++;
      if (got !== ev[i]) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%b expected=%b", name, i, got, ev[i]);
      end
      pnow = pend_m | (iv & mv);
      if (i == ev.size() - 1 && pnow) begin
        iv = (int'($urandom_range(99)) < irq_pct);
        mv = 1'($urandom_range(1));
        drive(1'b0, rand_op(), 3'($urandom_range(7)), iv, mv, 1'($urandom_range(1)));
        got = outs();
        checks++;
        if (got !== (E_INTT | E_PCW)) begin
          failures++;
          $display("FAIL %s trap got=%b expected=%b", name, got, E_INTT | E_PCW);
        end
        pend_m = iv & mv;
      end else begin
        pend_m = pnow;
      end
    end
  endtask

  task automatic test_reset();
    logic [9:0] got;
    drive(1'b1, OPR, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      drive(1'b0, OPR, 3'b000, 1'b0, 1'b0, 1'($urandom_range(1)));
      got = outs();
      checks++;
      if (got !== E_RST) begin
        failures++;
        $display("FAIL reset cycle=%0d got=%b expected=%b", c, got, E_RST);
      end
    end
    pend_m = 1'b0;
  endtask

  task automatic test_alu();
    run_instr("add", OPR, 3'b000, 0, 0, -1, 1'b0);
    run_instr("lui", LUI, 3'b101, 0, 0, -1, 1'b0);
    run_instr("jalr", JALR, 3'b000, 0, 0, -1, 1'b0);
  endtask

  task automatic test_branch_system_illegal();
    run_instr("branch", BRANCH, 3'b001, 0, 0, -1, 1'b0);
    run_instr("mret", SYSTEM, 3'b000, 0, 0, -1, 1'b0);
    run_instr("csrrw", SYSTEM, 3'b001, 0, 0, -1, 1'b0);
    run_instr("illegal", FENCE, 3'b000, 0, 0, -1, 1'b0);
  endtask

  task automatic test_load();
    run_instr("load_ready3", LOAD, 3'b010, 3, 0, -1, 1'b0);
    run_instr("load_ready1", LOAD, 3'b010, 1, 0, -1, 1'b0);
    run_instr("load_timeout", LOAD, 3'b010, T + 1, 0, -1, 1'b0);
  endtask

  task automatic test_store();
    run_instr("store_timeout", STORE, 3'b010, T + 1, 0, -1, 1'b0);
    run_instr("store_now", STORE, 3'b010, 0, 0, -1, 1'b0);
    run_instr("store_ready15", STORE, 3'b010, T, 0, -1, 1'b0);
  endtask

  task automatic test_intr();
    run_instr("load_irq_mie1", LOAD, 3'b010, 3, 0, 3, 1'b1);
    run_instr("load_irq_mie0", LOAD, 3'b010, 3, 0, 3, 1'b0);
    run_instr("add_irq_complete", OPR, 3'b000, 0, 0, 1, 1'b1);
  endtask

  task automatic test_rst_mid_swait();
    logic [9:0] got;
    logic [9:0] exp_q [5] = '{E_RD1, E_WE2, E_WE2, E_WE2, E_RST};
    logic       rst_q [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       irq_q [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(rst_q[i], STORE, 3'b010, irq_q[i], irq_q[i], 1'b0);
      got = outs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL rst_mid_swait cycle=%0d got=%b expected=%b", i, got, exp_q[i]);
      end
    end
    drive(1'b0, STORE, 3'b010, 1'b0, 1'b0, 1'b0);
    got = outs();
    checks++;
    if (got !== E_RST) begin
      failures++;
      $display("FAIL rst_mid_swait init2 got=%b expected=%b", got, E_RST);
    end
    pend_m = 1'b0;
    run_instr("after_rst_no_trap", OPR, 3'b000, 0, 0, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    int         ra;
    for (int k = 0; k < 60; k++) begin
      op = rand_op();
      ra = (op == LOAD) ? int'($urandom_range(T + 1, 1)) : int'($urandom_range(T + 1));
      run_instr("random", op, 3'($urandom_range(7)), ra, 12, -1, 1'b0);
    end
  endtask

  initial begin
    op_tab = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OPR, SYSTEM, FENCE, BAD};
    bus.CU_OPCODE = '0;
    bus.FUNC3     = '0;
    bus.INTR      = 1'b0;
    bus.MIE       = 1'b0;
    bus.MEM_READY = 1'b0;
    test_reset();
    test_alu();
    test_branch_system_illegal();
    test_load();
    test_store();
    test_intr();
    test_rst_mid_swait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
